// File: rtl/writeback_stage_if.sv
// Row-result handshake and RAM write-port bundle for writeback_stage.
// The stage itself connects through the slave modport.
interface writeback_stage_if #(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int ACC_SIZE  = 32
);
    logic                 init_start;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_SIZE-1:0]  acc_in;
    logic                 mem_grant;
    logic                 mem_we;
    logic [ADD_SIZE-1:0]  mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic                 busy;
    logic                 vec_done;

    modport master (
        output init_start, res_valid, acc_in, mem_grant,
        input  res_ready, mem_we, mem_addr, mem_wdata, busy, vec_done
    );

    modport slave (
        input  init_start, res_valid, acc_in, mem_grant,
        output res_ready, mem_we, mem_addr, mem_wdata, busy, vec_done
    );
endinterface

// File: rtl/writeback_stage.sv
// Euler writeback: rescales MAC row results, buffers them and writes the vector back to RAM.
// Optional build macro WB_SATURATE_EN: clamp rescaled results instead of wrapping them.
module writeback_stage #(
    parameter int                ADD_SIZE   = 16,
    parameter int                DATA_SIZE  = 16,
    parameter int                ACC_SIZE   = 32,
    parameter int                FRAC_BITS  = 8,
    parameter int                N_ROWS     = 50,
    parameter logic [ADD_SIZE-1:0] VEC_BASE = 16'h0000,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   wb
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(N_ROWS + 1);
    localparam logic [CNT_W-1:0] ROWS_ALL  = CNT_W'(N_ROWS);
    localparam logic [CNT_W-1:0] ROWS_LAST = CNT_W'(N_ROWS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [DATA_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]          rd_ptr;
    logic [AW:0]          wr_ptr;
    logic [ADD_SIZE-1:0]  wb_ptr;
    logic [CNT_W-1:0]     acc_cnt;
    logic [CNT_W-1:0]     wr_cnt;
    logic [DATA_SIZE-1:0] wb_word;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 running;
    logic                 push;
    logic                 pop;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

    // Outputs are forced low while reset is asserted, even before the first reset edge.
    // A restart flushes the FIFO, so neither a push nor a pop is offered in that cycle.
    assign running      = (state == RUN) && !reset && !wb.init_start;
    assign wb.res_ready = running && !fifo_full && (acc_cnt < ROWS_ALL);
    assign wb.mem_we    = running && !fifo_empty && wb.mem_grant;
    assign wb.mem_addr  = reset ? '0 : wb_ptr;
    assign wb.mem_wdata = reset ? '0 : fifo_mem[rd_ptr[AW-1:0]];
    assign wb.busy      = !reset && (state != IDLE);
    assign wb.vec_done  = !reset && (state == DONE);

    assign push = wb.res_valid && wb.res_ready;
    assign pop  = wb.mem_we;

`ifdef WB_SATURATE_EN
    logic signed [ACC_SIZE-1:0]   scaled;
    logic [ACC_SIZE-DATA_SIZE:0]  upper;

    assign scaled = $signed(wb.acc_in) >>> FRAC_BITS;
    assign upper  = scaled[ACC_SIZE-1:DATA_SIZE-1];

    // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
    always_comb begin
        wb_word = scaled[DATA_SIZE-1:0];
        if (!(&upper) && (|upper)) begin
            wb_word = upper[ACC_SIZE-DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                                : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
    end
`else
    assign wb_word = DATA_SIZE'($signed(wb.acc_in) >>> FRAC_BITS);
`endif

    // NOTE: storage array carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= wb_word;
        end
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            wb_ptr  <= VEC_BASE;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (wb.init_start) begin
            state   <= RUN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            wb_ptr  <= VEC_BASE;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + (AW+1)'(1);
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                wb_ptr <= wb_ptr + ADD_SIZE'(1);
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            case (state)
                IDLE:    state <= IDLE;
                RUN:     if (pop && (wr_cnt == ROWS_LAST)) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (N_ROWS=4, FRAC_BITS=8, FIFO_DEPTH=4).
// Two instances: VEC_BASE=0000 for the main scenarios, VEC_BASE=FFFE for address wrap.
module tb_writeback_stage;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    writeback_stage_if #(.ADD_SIZE(16), .DATA_SIZE(16), .ACC_SIZE(32)) ifa ();
    writeback_stage_if #(.ADD_SIZE(16), .DATA_SIZE(16), .ACC_SIZE(32)) ifb ();

    writeback_stage #(
        .ADD_SIZE(16), .DATA_SIZE(16), .ACC_SIZE(32), .FRAC_BITS(8),
        .N_ROWS(4), .VEC_BASE(16'h0000), .FIFO_DEPTH(4)
    ) dut_a (.clk(clk), .reset(reset), .wb(ifa));

    writeback_stage #(
        .ADD_SIZE(16), .DATA_SIZE(16), .ACC_SIZE(32), .FRAC_BITS(8),
        .N_ROWS(4), .VEC_BASE(16'hFFFE), .FIFO_DEPTH(4)
    ) dut_b (.clk(clk), .reset(reset), .wb(ifb));

    // Write log: {addr, data} and the cycle of each RAM write.
    logic [31:0] wq_a [$];
    logic [31:0] wq_b [$];
    int          wc_a [$];

    always @(negedge clk) begin
        if (!reset && ifa.mem_we) begin
            wq_a.push_back({ifa.mem_addr, ifa.mem_wdata});
            wc_a.push_back(cyc);
        end
        if (!reset && ifb.mem_we) wq_b.push_back({ifb.mem_addr, ifb.mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        ifa.init_start = 1'b1;
        tick();
        ifa.init_start = 1'b0;
        wq_a.delete();
        wc_a.delete();
    endtask

    // Offers each value for one cycle; the DUT must accept every one.
    task automatic push_a(input logic [31:0] vals [4], input string tag);
        for (int i = 0; i < 4; i++) begin
            ifa.res_valid = 1'b1;
            ifa.acc_in    = vals[i];
            @(negedge clk);
            vectors++;
            if (ifa.res_ready !== 1'b1)
                $display("FAIL %s_ready[%0d]: got %b want 1", tag, i, ifa.res_ready);
            if (ifa.res_ready !== 1'b1) miscompares++;
            tick();
        end
        ifa.res_valid = 1'b0;
    endtask

    // Returns at the negedge of the vec_done cycle, or with seen=0 after the budget.
    task automatic wait_done_a(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.vec_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_writes_a(input logic [31:0] expv [4], input string tag);
        logic [31:0] got;
        vectors++;
        if (wq_a.size() != 4) begin
            miscompares++;
            $display("FAIL %s_count: got %0d writes want 4", tag, wq_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq_a.size()) ? wq_a[i] : 32'hxxxx_xxxx;
            vectors++;
            if (got !== expv[i]) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got addr/data %h want %h", tag, i, got, expv[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v [4];
        @(negedge clk);
        vectors++;
        if ({ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_initial: got busy/rdy/we/done %b want 0000",
                     {ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done});
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        // Two results parked in the FIFO mid-RUN, then reset for two cycles.
        start_a();
        ifa.mem_grant = 1'b0;
        v = '{32'h0000_0100, 32'h0000_0200, 32'h0, 32'h0};
        for (int i = 0; i < 2; i++) begin
            ifa.res_valid = 1'b1;
            ifa.acc_in    = v[i];
            tick();
        end
        reset         = 1'b1;
        ifa.mem_grant = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_during: got busy/rdy/we/done %b want 0000",
                     {ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done});
        end
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_after: got busy/rdy/we/done %b want 0000",
                     {ifa.busy, ifa.res_ready, ifa.mem_we, ifa.vec_done});
        end
        ifa.res_valid = 1'b0;
        tick();
        // The FIFO must be empty after reset: a new run with grant but no pushes writes nothing.
        start_a();
        for (int k = 0; k < 3; k++) tick();
        vectors++;
        if (wq_a.size() != 0) begin
            miscompares++;
            $display("FAIL reset_fifo_empty: got %0d writes want 0", wq_a.size());
        end
        ifa.init_start = 1'b1;
        tick();
        ifa.init_start = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] v [4];
        logic [31:0] e [4];
        bit          seen;
        v = '{32'h0001_2345, 32'hFFFF_FF00, 32'h0000_0100, 32'h0000_0000};
        e = '{32'h0000_0123, 32'h0001_FFFF, 32'h0002_0001, 32'h0003_0000};
        ifa.mem_grant = 1'b1;
        start_a();
        push_a(v, "basic");
        wait_done_a(seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL basic_done_timeout: got no vec_done want pulse");
        end
        vectors++;
        if (wc_a.size() != 4 || cyc != wc_a[3] + 1) begin
            miscompares++;
            $display("FAIL basic_done_latency: got done cycle %0d want last write + 1 (%0d writes)",
                     cyc, wc_a.size());
        end
        vectors++;
        if (ifa.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_done: got %b want 1", ifa.busy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({ifa.busy, ifa.vec_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_idle: got busy/done %b want 00", {ifa.busy, ifa.vec_done});
        end
        tick();
        check_writes_a(e, "basic");
    endtask

    task automatic test_backpressure();
        logic [31:0] e [4];
        int          pushes;
        int          we_seen;
        bit          seen;
        e = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003, 32'h0003_0004};
        pushes  = 0;
        we_seen = 0;
        ifa.mem_grant = 1'b0;
        start_a();
        for (int c = 0; c < 10; c++) begin
            ifa.res_valid = 1'b1;
            ifa.acc_in    = (pushes + 1) << 8;
            @(negedge clk);
            if (ifa.res_ready === 1'b1) pushes++;
            if (ifa.mem_we !== 1'b0) we_seen++;
            if (c == 9) begin
                vectors++;
                if (pushes != 4 || ifa.res_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_ready_drop: got %0d pushes, ready %b want 4, 0",
                             pushes, ifa.res_ready);
                end
                vectors++;
                if ({ifa.mem_addr, ifa.mem_wdata} !== 32'h0000_0001) begin
                    miscompares++;
                    $display("FAIL bp_head_hold: got addr/data %h want 00000001",
                             {ifa.mem_addr, ifa.mem_wdata});
                end
            end
            tick();
        end
        vectors++;
        if (we_seen != 0) begin
            miscompares++;
            $display("FAIL bp_no_write: got %0d write cycles want 0", we_seen);
        end
        ifa.res_valid = 1'b0;
        ifa.mem_grant = 1'b1;
        wait_done_a(seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_done_timeout: got no vec_done want pulse");
        end
        tick();
        check_writes_a(e, "bp");
    endtask

    task automatic test_rescale();
        logic [31:0] v [4];
        logic [31:0] e [4];
        bit          seen;
        v = '{32'h0100_0000, 32'h8000_0000, 32'h007F_FFFF, 32'hFF80_0000};
`ifdef WB_SATURATE_EN
        e = '{32'h0000_7FFF, 32'h0001_8000, 32'h0002_7FFF, 32'h0003_8000};
`else
        e = '{32'h0000_0000, 32'h0001_0000, 32'h0002_7FFF, 32'h0003_8000};
`endif
        ifa.mem_grant = 1'b1;
        start_a();
        push_a(v, "rescale");
        wait_done_a(seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rescale_done_timeout: got no vec_done want pulse");
        end
        tick();
        check_writes_a(e, "rescale");
    endtask

    task automatic test_restart();
        logic [31:0] v [4];
        logic [31:0] e [4];
        bit          seen;
        int          bad;
        v = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};
        ifa.mem_grant = 1'b0;
        start_a();
        push_a(v, "restart_fill");
        ifa.mem_grant = 1'b1;
        tick();
        tick();
        ifa.init_start = 1'b1;
        @(negedge clk);
        vectors++;
        if (ifa.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_override: got mem_we %b want 0", ifa.mem_we);
        end
        tick();
        ifa.init_start = 1'b0;
        vectors++;
        if (wq_a.size() != 2) begin
            miscompares++;
            $display("FAIL restart_partial: got %0d writes want 2", wq_a.size());
        end
        wq_a.delete();
        wc_a.delete();
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ifa.mem_we !== 1'b0 || ifa.vec_done !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL restart_flushed: got %0d cycles with write/done want 0", bad);
        end
        v = '{32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00, 32'h0000_0D00};
        e = '{32'h0000_000A, 32'h0001_000B, 32'h0002_000C, 32'h0003_000D};
        push_a(v, "restart_new");
        wait_done_a(seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL restart_done_timeout: got no vec_done want pulse");
        end
        tick();
        check_writes_a(e, "restart");
    endtask

    task automatic test_wrap();
        logic [31:0] e [4];
        logic [31:0] got;
        bit          seen;
        e = '{32'hFFFE_0001, 32'hFFFF_0002, 32'h0000_0003, 32'h0001_0004};
        ifb.mem_grant  = 1'b1;
        ifb.init_start = 1'b1;
        tick();
        ifb.init_start = 1'b0;
        wq_b.delete();
        for (int i = 0; i < 4; i++) begin
            ifb.res_valid = 1'b1;
            ifb.acc_in    = (i + 1) << 8;
            tick();
        end
        ifb.res_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ifb.vec_done === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wrap_done_timeout: got no vec_done want pulse");
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq_b.size()) ? wq_b[i] : 32'hxxxx_xxxx;
            vectors++;
            if (got !== e[i]) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: got addr/data %h want %h", i, got, e[i]);
            end
        end
    endtask

    initial begin
        ifa.init_start = 1'b0; ifa.res_valid = 1'b0; ifa.acc_in = '0; ifa.mem_grant = 1'b0;
        ifb.init_start = 1'b0; ifb.res_valid = 1'b0; ifb.acc_in = '0; ifb.mem_grant = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_rescale();
        test_restart();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
